// File: rtl/tone_scheduler.sv
// Round-robin arbiter sharing one square-wave tone generator among four note requesters.
// Latency: request sampled at edge k -> ack/busy/tone_en/tone_period valid in cycle k+1.
// Backpressure: one note at a time; other requests wait in IDLE, no preemption.
//
// Ports:
//   clock, reset (async, active-low)
//   req[3:0]          level requests, held until ack
//   req_period[79:0]  four 20-bit half-periods, requester i at [20i+19:20i]
//   req_duration[19:0] four 5-bit durations in 1/8 s units, requester i at [5i+4:5i]
//   abort             stop the current note/gap, return to IDLE without done
//   ack[3:0]          one-cycle pulse when request i is accepted
//   done[3:0]         one-cycle pulse when note i (gap included) finishes
//   grant_id[1:0]     owner of the generator
//   busy              high while playing or in the gap
//   tone_period[19:0] half-period to the tone generator
//   tone_en           tone generator enable
module tone_scheduler #(
    parameter int CLK_FREQ   = 100_000_000,
    parameter int GAP_CYCLES = 1_000_000
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [3:0]  req,
    input  logic [79:0] req_period,
    input  logic [19:0] req_duration,
    input  logic        abort,
    output logic [3:0]  ack,
    output logic [3:0]  done,
    output logic [1:0]  grant_id,
    output logic        busy,
    output logic [19:0] tone_period,
    output logic        tone_en
);

    localparam int UNIT_CYCLES = CLK_FREQ / 8;
    localparam int UNIT_W      = (UNIT_CYCLES > 1) ? $clog2(UNIT_CYCLES) : 1;
    localparam int GAP_W       = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam logic [UNIT_W-1:0] UNIT_LAST = UNIT_W'(UNIT_CYCLES - 1);
    localparam logic [UNIT_W-1:0] UNIT_ONE  = 1;
    localparam logic [GAP_W-1:0]  GAP_LAST  = GAP_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
    localparam logic [GAP_W-1:0]  GAP_ONE   = 1;

    typedef enum logic [1:0] {S_IDLE, S_PLAY, S_GAP} state_t;

    state_t            state, state_n;
    logic [1:0]        last_grant, last_n;
    logic [4:0]        rem, rem_n;
    logic [UNIT_W-1:0] unit_cnt, unit_n;
    logic [GAP_W-1:0]  gap_cnt, gap_n;
    logic [3:0]        ack_n, done_n;
    logic [1:0]        grant_n;
    logic              busy_n, en_n;
    logic [19:0]       period_n;

    logic              win_vld;
    logic [1:0]        win_id;
    logic [1:0]        cand;
    logic [19:0]       sel_period;
    logic [4:0]        sel_dur;
    logic              unit_wrap;

    // Round-robin search starting just after the previous winner.
    always_comb begin
        win_vld = 1'b0;
        win_id  = 2'd0;
        cand    = 2'd0;
        for (int i = 0; i < 4; i++) begin
            cand = last_grant + 2'(i + 1);
            if (!win_vld && req[cand]) begin
                win_vld = 1'b1;
                win_id  = cand;
            end
        end
    end

    assign sel_period = req_period[20*win_id +: 20];
    assign sel_dur    = req_duration[5*win_id +: 5];
    assign unit_wrap  = (unit_cnt == UNIT_LAST);

    always_comb begin
        state_n  = state;
        last_n   = last_grant;
        rem_n    = rem;
        unit_n   = unit_cnt;
        gap_n    = gap_cnt;
        ack_n    = 4'b0000;
        done_n   = 4'b0000;
        grant_n  = grant_id;
        busy_n   = busy;
        en_n     = tone_en;
        period_n = tone_period;
        case (state)
            S_IDLE: begin
                // abort in IDLE suppresses the grant on that edge
                if (!abort && win_vld) begin
                    state_n  = S_PLAY;
                    ack_n    = 4'b0001 << win_id;
                    grant_n  = win_id;
                    last_n   = win_id;
                    busy_n   = 1'b1;
                    period_n = sel_period;
                    rem_n    = sel_dur;
                    unit_n   = '0;
                    // half-period below 2 is a silent rest; zero duration never sounds
                    en_n     = (sel_period >= 20'd2) && (sel_dur != 5'd0);
                end
            end
            S_PLAY: begin
                if (abort) begin
                    state_n = S_IDLE;
                    en_n    = 1'b0;
                    busy_n  = 1'b0;
                    rem_n   = '0;
                    unit_n  = '0;
                    gap_n   = '0;
                end else if (rem == 5'd0 || (unit_wrap && rem == 5'd1)) begin
                    en_n   = 1'b0;
                    rem_n  = '0;
                    unit_n = '0;
                    if (GAP_CYCLES > 0) begin
                        state_n = S_GAP;
                        gap_n   = '0;
                    end else begin
                        state_n = S_IDLE;
                        done_n  = 4'b0001 << grant_id;
                        busy_n  = 1'b0;
                    end
                end else if (unit_wrap) begin
                    unit_n = '0;
                    rem_n  = rem - 5'd1;
                end else begin
                    unit_n = unit_cnt + UNIT_ONE;
                end
            end
            S_GAP: begin
                if (abort) begin
                    state_n = S_IDLE;
                    en_n    = 1'b0;
                    busy_n  = 1'b0;
                    rem_n   = '0;
                    unit_n  = '0;
                    gap_n   = '0;
                end else if (gap_cnt == GAP_LAST) begin
                    state_n = S_IDLE;
                    done_n  = 4'b0001 << grant_id;
                    busy_n  = 1'b0;
                    gap_n   = '0;
                end else begin
                    gap_n = gap_cnt + GAP_ONE;
                end
            end
            default: begin
                state_n = S_IDLE;
                en_n    = 1'b0;
                busy_n  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state       <= S_IDLE;
            last_grant  <= 2'd3;
            rem         <= '0;
            unit_cnt    <= '0;
            gap_cnt     <= '0;
            ack         <= 4'b0000;
            done        <= 4'b0000;
            grant_id    <= 2'd0;
            busy        <= 1'b0;
            tone_en     <= 1'b0;
            tone_period <= '0;
        end else begin
            state       <= state_n;
            last_grant  <= last_n;
            rem         <= rem_n;
            unit_cnt    <= unit_n;
            gap_cnt     <= gap_n;
            ack         <= ack_n;
            done        <= done_n;
            grant_id    <= grant_n;
            busy        <= busy_n;
            tone_en     <= en_n;
            tone_period <= period_n;
        end
    end

endmodule

// File: tb/tb_tone_scheduler.sv
// Scoreboard bench for tone_scheduler: stimulus pushes expected ack/done/abort
// events with hand-computed cycle stamps; a monitor pops and compares them.
// Runs with CLK_FREQ = 80 (10-cycle duration unit) and a 4-cycle gap.
module tb_tone_scheduler;

    localparam int K_ACK   = 0;
    localparam int K_DONE  = 1;
    localparam int K_ABORT = 2;

    typedef struct {
        int kind;
        int cyc;
        int id;
        int period;
        int en;
        int tone;
        int busy;
    } exp_t;

    logic        clock;
    logic        reset;
    logic [3:0]  req;
    logic [79:0] req_period;
    logic [19:0] req_duration;
    logic        abort;
    logic [3:0]  ack;
    logic [3:0]  done;
    logic [1:0]  grant_id;
    logic        busy;
    logic [19:0] tone_period;
    logic        tone_en;

    int   checks;
    int   errors;
    int   cyc;
    int   tone_cnt;
    int   busy_cnt;
    logic prev_busy;
    exp_t q[$];

    tone_scheduler #(.CLK_FREQ(80), .GAP_CYCLES(4)) dut (
        .clock        (clock),
        .reset        (reset),
        .req          (req),
        .req_period   (req_period),
        .req_duration (req_duration),
        .abort        (abort),
        .ack          (ack),
        .done         (done),
        .grant_id     (grant_id),
        .busy         (busy),
        .tone_period  (tone_period),
        .tone_en      (tone_en)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    task automatic push(input int kind, input int c, input int id, input int period,
                        input int en, input int tone, input int bsy);
        exp_t e;
        e.kind = kind; e.cyc = c; e.id = id; e.period = period;
        e.en = en; e.tone = tone; e.busy = bsy;
        q.push_back(e);
    endtask

    task automatic handle(input int kind, input string name);
        exp_t e;
        logic ok;
        checks++;
        if (q.size() == 0) begin
            errors++;
            $display("FAIL %s: unexpected event at cyc=%0d ack=%b done=%b busy=%b, required none",
                     name, cyc, ack, done, busy);
        end else begin
            e = q.pop_front();
            ok = (e.kind == kind) && (e.cyc == cyc);
            if (kind == K_ACK)
                ok = ok && (ack == 4'(4'b0001 << e.id)) && (int'(grant_id) == e.id) &&
                     (int'(tone_period) == e.period) && (int'(tone_en) == e.en) && busy;
            else if (kind == K_DONE)
                ok = ok && (done == 4'(4'b0001 << e.id)) && !busy && !tone_en &&
                     (tone_cnt == e.tone) && (busy_cnt == e.busy);
            else
                ok = ok && !tone_en && (tone_cnt == e.tone) && (busy_cnt == e.busy);
            if (!ok) begin
                errors++;
                $display("FAIL %s: got cyc=%0d ack=%b done=%b gid=%0d period=%0d en=%b busy=%b tone_cycles=%0d busy_cycles=%0d; required kind=%0d cyc=%0d id=%0d period=%0d en=%0d tone_cycles=%0d busy_cycles=%0d",
                         name, cyc, ack, done, grant_id, tone_period, tone_en, busy, tone_cnt, busy_cnt,
                         e.kind, e.cyc, e.id, e.period, e.en, e.tone, e.busy);
            end
        end
    endtask

    task automatic monitor();
        prev_busy = 1'b0;
        tone_cnt  = 0;
        busy_cnt  = 0;
        forever begin
            @(negedge clock);
            if (ack != 4'b0000) begin
                handle(K_ACK, "ack");
                tone_cnt = int'(tone_en);
                busy_cnt = int'(busy);
            end else begin
                tone_cnt += int'(tone_en);
                busy_cnt += int'(busy);
            end
            if (done != 4'b0000) handle(K_DONE, "done");
            if (prev_busy && !busy && done == 4'b0000) handle(K_ABORT, "abort");
            prev_busy = busy;
        end
    endtask

    task automatic chk(input string name, input int got, input int want);
        checks++;
        if (got != want) begin
            errors++;
            $display("FAIL %s: got %0d, required %0d", name, got, want);
        end
    endtask

    // One cycle; a requester drops its request once it has seen ack.
    task automatic tick();
        @(negedge clock);
        req = req & ~ack;
    endtask

    task automatic set_req(input int id, input int period, input int dur);
        req_period[20*id +: 20]  = 20'(period);
        req_duration[5*id +: 5]  = 5'(dur);
        req[id]                  = 1'b1;
    endtask

    task automatic wait_idle(input string name, input int bound);
        for (int i = 0; i < bound; i++) begin
            tick();
            if (q.size() == 0 && !busy) return;
        end
        checks++;
        errors++;
        $display("FAIL %s: timeout, %0d expected events outstanding, required 0", name, q.size());
        q.delete();
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_ack"},     int'(ack),         0);
        chk({tag, "_done"},    int'(done),        0);
        chk({tag, "_busy"},    int'(busy),        0);
        chk({tag, "_tone_en"}, int'(tone_en),     0);
        chk({tag, "_period"},  int'(tone_period), 0);
        chk({tag, "_grant"},   int'(grant_id),    0);
    endtask

    initial begin
        int c;
        checks       = 0;
        errors       = 0;
        reset        = 1'b0;
        req          = 4'b0000;
        req_period   = '0;
        req_duration = '0;
        abort        = 1'b0;
        fork
            monitor();
        join_none

        repeat (3) tick();
        check_reset_outputs("reset");
        reset = 1'b1;
        tick();

        // Contention 1011, one unit each: order 0, 1, 3, acks 15 cycles apart.
        c = cyc;
        set_req(0, 100, 1); set_req(1, 200, 1); set_req(3, 300, 1);
        push(K_ACK,  c + 1,  0, 100, 1, 0, 0);
        push(K_DONE, c + 15, 0, 0,   0, 10, 14);
        push(K_ACK,  c + 16, 1, 200, 1, 0, 0);
        push(K_DONE, c + 30, 1, 0,   0, 10, 14);
        push(K_ACK,  c + 31, 3, 300, 1, 0, 0);
        push(K_DONE, c + 45, 3, 0,   0, 10, 14);
        wait_idle("contention", 100);

        // Single note: 30 tone cycles + 4 gap cycles.
        c = cyc;
        set_req(2, 5, 3);
        push(K_ACK,  c + 1,  2, 5, 1, 0, 0);
        push(K_DONE, c + 35, 2, 0, 0, 30, 34);
        wait_idle("single", 100);

        // Rest note: period 1 stays silent for the full 24 busy cycles.
        c = cyc;
        set_req(1, 1, 2);
        push(K_ACK,  c + 1,  1, 1, 0, 0, 0);
        push(K_DONE, c + 25, 1, 0, 0, 0, 24);
        wait_idle("rest", 100);

        // Zero duration: one silent play cycle then the gap.
        c = cyc;
        set_req(0, 50, 0);
        push(K_ACK,  c + 1, 0, 50, 0, 0, 0);
        push(K_DONE, c + 6, 0, 0,  0, 0, 5);
        wait_idle("zero_dur", 50);

        // Abort while idle blocks the grant for that edge only.
        c = cyc;
        abort = 1'b1;
        set_req(0, 60, 0);
        push(K_ACK,  c + 2, 0, 60, 0, 0, 0);
        push(K_DONE, c + 7, 0, 0,  0, 0, 5);
        tick();
        abort = 1'b0;
        wait_idle("idle_abort", 50);

        // Abort in cycle 7 of a 20-cycle note; pending req[3] granted right after.
        c = cyc;
        set_req(2, 9, 2);
        push(K_ACK, c + 1, 2, 9, 1, 0, 0);
        tick();
        set_req(3, 33, 1);
        repeat (6) tick();
        abort = 1'b1;
        push(K_ABORT, c + 8, 0, 0, 0, 7, 7);
        tick();
        abort = 1'b0;
        push(K_ACK,  c + 9,  3, 33, 1, 0, 0);
        push(K_DONE, c + 23, 3, 0,  0, 10, 14);
        wait_idle("play_abort", 100);

        // Reset mid-note clears outputs at once; afterwards requester 0 wins first.
        c = cyc;
        set_req(1, 7, 3);
        push(K_ACK, c + 1, 1, 7, 1, 0, 0);
        repeat (5) tick();
        #2;
        reset = 1'b0;
        push(K_ABORT, c + 6, 0, 0, 0, 5, 5);
        #1;
        check_reset_outputs("midreset");
        repeat (2) tick();
        reset = 1'b1;
        c = cyc;
        set_req(0, 11, 1); set_req(1, 12, 1);
        push(K_ACK,  c + 1,  0, 11, 1, 0, 0);
        push(K_DONE, c + 15, 0, 0,  0, 10, 14);
        push(K_ACK,  c + 16, 1, 12, 1, 0, 0);
        push(K_DONE, c + 30, 1, 0,  0, 10, 14);
        wait_idle("post_reset", 100);

        repeat (3) tick();
        chk("queue_empty", q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/tone_scheduler.md
# tone_scheduler

Round-robin scheduler that shares the single square-wave tone generator between four note requesters (e.g. song sequencer, key-click beeper, alarm, test tone). It accepts one note request at a time, drives the generator's half-period and enable for exactly the requested duration, inserts a silent articulation gap, then reports completion. It sits between the note sources and the tone-generator datapath.

## Interface
- CLK_FREQ, 100_000_000, clock frequency in Hz; one duration unit = CLK_FREQ/8 cycles (UNIT_CYCLES)
- GAP_CYCLES, 1_000_000, silent cycles inserted after every note; 0 disables the gap
- clock  in  1  system clock; one clock domain
- reset  in  1  asynchronous, active-low reset
- req  in  4  per-requester note request, level, held until ack
- req_period  in  80  four 20-bit half-periods in clock cycles; bits [20i+19:20i] belong to requester i
- req_duration  in  20  four 5-bit durations in 1/8 s units; bits [5i+4:5i] belong to requester i
- abort  in  1  synchronous stop of the current note/gap
- ack  out  4  one-cycle pulse: request i accepted
- done  out  4  one-cycle pulse: note of requester i finished, gap included
- grant_id  out  2  index of requester currently owning the generator
- busy  out  1  high in PLAY and GAP
- tone_period  out  20  half-period to the tone generator
- tone_en  out  1  tone generator enable

## Operation
- States: IDLE, PLAY, GAP. All outputs registered.
- IDLE: if any req bit high at a clock edge, select winner by round-robin: search from (last_grant+1) mod 4 upward, wrapping. At that edge: latch winner's period and duration, grant_id <= winner, last_grant <= winner, ack[winner] <= 1, busy <= 1, enter PLAY.
- Rest rule: latched period < 2 -> tone_en = 0 for the whole note (silent rest, same duration); otherwise tone_en = 1 in PLAY.
- PLAY: unit counter counts 0..UNIT_CYCLES-1; on wrap, remaining duration decrements. When remaining reaches 0: tone_en <= 0; enter GAP if GAP_CYCLES > 0, else pulse done[grant_id] and enter IDLE.
- Duration 0: note accepted and acked, PLAY lasts exactly 1 cycle with tone_en = 0, then normal GAP/IDLE path.
- GAP: count GAP_CYCLES cycles with tone_en = 0; on last cycle pulse done[grant_id], busy <= 0, enter IDLE.
- Requester protocol: requester must drop req at the first edge after it sees ack; req/period/duration are ignored outside IDLE. A req still high when IDLE is re-entered is a new request.
- abort (PLAY or GAP): next edge -> IDLE, tone_en = 0, busy = 0, no done pulse, counters cleared. abort in IDLE: ignored, and IDLE does not grant on that edge.
- tone_period holds the last latched value after the note ends (tone_en gates it).
- Requests arriving during PLAY/GAP wait; no preemption.

## Timing
- Reset (asynchronous, active-low): state IDLE, ack = 0, done = 0, busy = 0, tone_en = 0, tone_period = 0, grant_id = 0, last_grant = 3 (requester 0 wins first), counters 0. Reset mid-note aborts silently.
- Grant latency: req sampled high at edge k -> ack, busy, tone_en, tone_period valid in cycle k+1.
- Note length: tone_en high for exactly duration*UNIT_CYCLES cycles.
- done pulses on the last GAP cycle; IDLE can grant again at the next edge. Minimum back-to-back spacing between consecutive acks = duration*UNIT_CYCLES + GAP_CYCLES + 1 cycles.
- ack and done are never both high for the same requester in one cycle except when GAP_CYCLES = 0 and duration = 0 cannot coincide (done follows ack by ≥1 cycle).

## Test plan
Bench parameters: CLK_FREQ = 80 (UNIT_CYCLES = 10), GAP_CYCLES = 4.
- Single request: req[2] with period 5, duration 3 -> ack[2] one cycle after sampling, grant_id = 2, tone_en high 30 cycles with tone_period = 5, then 4 gap cycles, done[2] on last gap cycle, busy low after.
- Contention: req = 4'b1011 held, each dropped after its ack, duration 1 -> grant order 0, 1, 3; acks spaced 15 cycles apart.
- Rest note: req[1], period 1, duration 2 -> busy 24 cycles, tone_en stays 0 throughout, done[1] pulses.
- Zero duration: req[0], duration 0 -> ack[0], 1 PLAY cycle with tone_en = 0, 4 gap cycles, done[0].
- Abort: abort asserted at cycle 7 of a 20-cycle note -> next cycle IDLE, tone_en = 0, busy = 0, no done; pending req[3] granted on the following edge.
- Reset mid-note: reset low during PLAY -> all outputs to reset values immediately; after release, req[1] and req[0] both high -> requester 0 granted first.
